// File: rtl/reg_arb_pkg.sv
// Shared types and the round-robin search used by the register write arbiter.
package reg_arb_pkg;

  // Arbiter control states: waiting to pick a requester, or serving one.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Upper bound on requesters; the search works on vectors of this width.
  localparam int unsigned MAX_REQ   = 16;
  localparam int unsigned MAX_IDX_W = 4;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req at or after ptr, wrapping modulo num.
  function automatic rr_pick_t rr_first(
    input logic [MAX_REQ-1:0]   req,
    input logic [MAX_IDX_W-1:0] ptr,
    input int unsigned          num
  );
    rr_pick_t    res;
    int unsigned j;
    res = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= num) begin
        j = j - num;
      end
      if ((k < num) && !res.found && req[j[MAX_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = j[MAX_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/RegisterFDRE.sv
// Load-enable register with asynchronous active-low clear.
module RegisterFDRE #(
  parameter int unsigned SIZE = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            enable,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);

  // Capture d when enabled; clear immediately on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin selector: request vector and pointer in,
// winning index and a found flag out.
module rr_picker
  import reg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [MAX_REQ-1:0] req_ext;
  rr_pick_t           pick;

  // Zero-extend the request vector to the search width.
  for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_ext
    if (gi < NUM_REQ) begin : g_used
      assign req_ext[gi] = req_i[gi];
    end else begin : g_pad
      assign req_ext[gi] = 1'b0;
    end
  end

  assign pick    = rr_first(req_ext, MAX_IDX_W'(ptr_i), NUM_REQ);
  assign found_o = pick.found;
  assign idx_o   = pick.idx[IDX_W-1:0];

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one load-enable register among NUM_REQ
// burst requesters. Accepted words reach the register outputs one cycle
// after acceptance; a grant ends on last or after MAX_BEATS words.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned SIZE      = 32,
  parameter int unsigned MAX_BEATS = 16,
  localparam int unsigned IDX_W    = $clog2(NUM_REQ),
  localparam int unsigned CNT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_last,
  input  logic [NUM_REQ*SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    reg_enable,
  output logic [SIZE-1:0]         reg_d,
  output logic [IDX_W-1:0]        reg_owner,
  output logic                    busy,
  output logic                    done,
  output logic                    truncated
);

  state_e           state_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic             enable_q;
  logic             done_q;
  logic             trunc_q;

  logic [SIZE-1:0]       data_arr [NUM_REQ];
  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic                  accept;
  logic                  hit_last;
  logic                  hit_max;
  logic                  release_grant;
  logic [IDX_W-1:0]      next_ptr;
  logic [IDX_W+SIZE-1:0] out_d;
  logic [IDX_W+SIZE-1:0] out_q;

  // Unpack the flat data bus and build the ready vector from state and
  // owner only, so ready never depends on the requester's valid.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign data_arr[gi]  = req_data[gi*SIZE +: SIZE];
    assign req_ready[gi] = (state_q == GRANT) && (owner_q == IDX_W'(gi));
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign accept        = (state_q == GRANT) && req_valid[owner_q];
  assign hit_last      = req_last[owner_q];
  assign hit_max       = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
  assign release_grant = accept && (hit_last || hit_max);
  assign next_ptr      = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // Arbitration FSM with registered enable/done/truncated pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      enable_q   <= 1'b0;
      done_q     <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      enable_q <= accept;
      done_q   <= release_grant;
      trunc_q  <= release_grant && !hit_last;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            owner_q    <= pick_idx;
            beat_cnt_q <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          if (accept) begin
            // Count reaches at most MAX_BEATS, which fits CNT_W.
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (release_grant) begin
              state_q  <= IDLE;
              rr_ptr_q <= next_ptr;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output stage: owner and data captured together on each accepted beat.
  assign out_d = {owner_q, data_arr[owner_q]};

  RegisterFDRE #(
    .SIZE (IDX_W + SIZE)
  ) u_out_reg (
    .clk    (clk),
    .resetn (resetn),
    .enable (accept),
    .d      (out_d),
    .q      (out_q)
  );

  assign reg_d      = out_q[SIZE-1:0];
  assign reg_owner  = out_q[IDX_W+SIZE-1:SIZE];
  assign reg_enable = enable_q;
  assign busy       = (state_q == GRANT);
  assign done       = done_q;
  assign truncated  = trunc_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (NUM_REQ=4, SIZE=32, MAX_BEATS=4).
module tb_reg_write_arbiter;

  logic         clk;
  logic         resetn;
  logic [3:0]   req_valid;
  logic [3:0]   req_last;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         reg_enable;
  logic [31:0]  reg_d;
  logic [1:0]   reg_owner;
  logic         busy;
  logic         done;
  logic         truncated;

  int n_assert = 0;
  int n_fail   = 0;

  reg_write_arbiter #(
    .NUM_REQ   (4),
    .SIZE      (32),
    .MAX_BEATS (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .reg_enable (reg_enable),
    .reg_d      (reg_d),
    .reg_owner  (reg_owner),
    .busy       (busy),
    .done       (done),
    .truncated  (truncated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [31:0] v);
    req_data[idx*32 +: 32] = v;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] rdy, input logic bsy,
                         input logic en, input logic [31:0] d, input logic [1:0] own,
                         input logic dn, input logic tr);
    chk({tag, ".ready"}, 64'(req_ready), 64'(rdy));
    chk({tag, ".busy"}, 64'(busy), 64'(bsy));
    chk({tag, ".enable"}, 64'(reg_enable), 64'(en));
    chk({tag, ".reg_d"}, 64'(reg_d), 64'(d));
    chk({tag, ".owner"}, 64'(reg_owner), 64'(own));
    chk({tag, ".done"}, 64'(done), 64'(dn));
    chk({tag, ".trunc"}, 64'(truncated), 64'(tr));
    $display("step %-12s t=%0t ready=%b busy=%b en=%b d=%h own=%0d done=%b trunc=%b",
             tag, $time, req_ready, busy, reg_enable, reg_d, reg_owner, done, truncated);
  endtask

  localparam logic [31:0] A  = 32'hA000_000A;
  localparam logic [31:0] B  = 32'hB000_000B;
  localparam logic [31:0] C  = 32'hC000_000C;
  localparam logic [31:0] D0 = 32'hD000_0000;
  localparam logic [31:0] D3 = 32'hD000_0003;
  localparam logic [31:0] G1 = 32'h6100_0001;
  localparam logic [31:0] G2 = 32'h6200_0002;
  localparam logic [31:0] Y  = 32'h7700_0002;
  localparam logic [31:0] Z  = 32'h5A00_0003;

  logic [31:0] wv [6];
  logic [31:0] rv [4];
  int          order [5];
  logic [31:0] prev_d;
  logic [1:0]  prev_own;

  initial begin
    wv[0] = 32'h1111_0001; wv[1] = 32'h1111_0002; wv[2] = 32'h1111_0003;
    wv[3] = 32'h1111_0004; wv[4] = 32'h1111_0005; wv[5] = 32'h1111_0006;
    rv[0] = 32'h2222_0000; rv[1] = 32'h2222_0001; rv[2] = 32'h2222_0002; rv[3] = 32'h2222_0003;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;

    resetn    = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    #2 resetn = 1'b0;
    step();
    step();
    chk_all("reset", 4'b0000, 0, 0, 32'h0, 2'd0, 0, 0);
    resetn = 1'b1;

    // Single requester: req 2 sends A, B, C (last on C)
    req_valid = 4'b0100; set_data(2, A);
    step(); chk_all("t1_grant", 4'b0100, 1, 0, 32'h0, 2'd0, 0, 0);
    step(); chk_all("t1_A", 4'b0100, 1, 1, A, 2'd2, 0, 0);
    set_data(2, B);
    step(); chk_all("t1_B", 4'b0100, 1, 1, B, 2'd2, 0, 0);
    set_data(2, C); req_last = 4'b0100;
    step(); chk_all("t1_C", 4'b0000, 0, 1, C, 2'd2, 1, 0);
    req_valid = '0; req_last = '0;
    step(); chk_all("t1_idle", 4'b0000, 0, 0, C, 2'd2, 0, 0);

    // Wrap-around: rr_ptr=3, req 0 and req 3 valid
    req_valid = 4'b1001; req_last = 4'b1001; set_data(0, D0); set_data(3, D3);
    step(); chk_all("wr_g3", 4'b1000, 1, 0, C, 2'd2, 0, 0);
    step(); chk_all("wr_d3", 4'b0000, 0, 1, D3, 2'd3, 1, 0);
    req_valid = 4'b0001;
    step(); chk_all("wr_g0", 4'b0001, 1, 0, D3, 2'd3, 0, 0);
    step(); chk_all("wr_d0", 4'b0000, 0, 1, D0, 2'd0, 1, 0);
    req_valid = '0; req_last = '0;
    step(); chk_all("wr_idle", 4'b0000, 0, 0, D0, 2'd0, 0, 0);

    // Valid gaps: req 0 word, 3-cycle stall, last word; req 2 waits
    req_valid = 4'b0001; set_data(0, G1);
    step(); chk_all("gp_grant", 4'b0001, 1, 0, D0, 2'd0, 0, 0);
    step(); chk_all("gp_w1", 4'b0001, 1, 1, G1, 2'd0, 0, 0);
    req_valid = 4'b0100; req_last = 4'b0100; set_data(2, Y);
    for (int s = 0; s < 3; s++) begin
      step(); chk_all("gp_stall", 4'b0001, 1, 0, G1, 2'd0, 0, 0);
    end
    req_valid = 4'b0101; req_last = 4'b0101; set_data(0, G2);
    step(); chk_all("gp_w2", 4'b0000, 0, 1, G2, 2'd0, 1, 0);
    req_valid = 4'b0100;
    step(); chk_all("gp_g2", 4'b0100, 1, 0, G2, 2'd0, 0, 0);
    step(); chk_all("gp_y", 4'b0000, 0, 1, Y, 2'd2, 1, 0);
    req_valid = '0; req_last = '0;
    step(); chk_all("gp_idle", 4'b0000, 0, 0, Y, 2'd2, 0, 0);

    // MAX_BEATS=4: req 1 streams without last; req 3 pending
    req_valid = 4'b0010; set_data(1, wv[0]);
    step(); chk_all("mb_grant", 4'b0010, 1, 0, Y, 2'd2, 0, 0);
    req_valid = 4'b1010; req_last = 4'b1000; set_data(3, Z);
    for (int w = 0; w < 3; w++) begin
      step(); chk_all("mb_word", 4'b0010, 1, 1, wv[w], 2'd1, 0, 0);
      set_data(1, wv[w+1]);
    end
    step(); chk_all("mb_w4", 4'b0000, 0, 1, wv[3], 2'd1, 1, 1);
    set_data(1, wv[4]);
    step(); chk_all("mb_g3", 4'b1000, 1, 0, wv[3], 2'd1, 0, 0);
    step(); chk_all("mb_z", 4'b0000, 0, 1, Z, 2'd3, 1, 0);
    req_valid = 4'b0010; req_last = '0;
    step(); chk_all("mb_regrant", 4'b0010, 1, 0, Z, 2'd3, 0, 0);
    step(); chk_all("mb_w5", 4'b0010, 1, 1, wv[4], 2'd1, 0, 0);
    set_data(1, wv[5]);
    step(); chk_all("mb_w6", 4'b0010, 1, 1, wv[5], 2'd1, 0, 0);

    // Async reset mid-burst, between clock edges
    #3 resetn = 1'b0;
    #1 chk_all("ar_instant", 4'b0000, 0, 0, 32'h0, 2'd0, 0, 0);
    step(); chk_all("ar_held", 4'b0000, 0, 0, 32'h0, 2'd0, 0, 0);
    resetn = 1'b1;

    // Round-robin from reset: all four valid with single-word bursts
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int i = 0; i < 4; i++) set_data(i, rv[i]);
    prev_d = 32'h0; prev_own = 2'd0;
    for (int k = 0; k < 5; k++) begin
      step(); chk_all("rr_grant", 4'(1 << order[k]), 1, 0, prev_d, prev_own, 0, 0);
      step(); chk_all("rr_data", 4'b0000, 0, 1, rv[order[k]], 2'(order[k]), 1, 0);
      prev_d = rv[order[k]]; prev_own = 2'(order[k]);
    end
    req_valid = '0; req_last = '0;
    step(); chk_all("rr_idle", 4'b0000, 0, 0, prev_d, prev_own, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin arbiter that shares one RegisterFDRE-style load-enable register among NUM_REQ requesters.
- Each requester sends bursts of SIZE-bit words with a valid/ready/last handshake.
- The arbiter grants one requester at a time and forwards the accepted words to the shared register's d/enable inputs, one cycle after acceptance.
- It sits between the BIKE datapath units (for example the sampler and multiplier) and a shared result or accumulator register.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- SIZE, 32, data width of the shared register.
- MAX_BEATS, 16, maximum words per grant before the arbiter forces release (≥1).
- IDX_W, $clog2(NUM_REQ), width of the requester index (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_last  in  NUM_REQ  per-requester last-word flag, qualified by valid.
- req_data  in  NUM_REQ*SIZE  per-requester data; slice i is bits [i*SIZE +: SIZE].
- req_ready  out  NUM_REQ  per-requester word accept; at most one bit set.
- reg_enable  out  1  enable to the shared register.
- reg_d  out  SIZE  data to the shared register.
- reg_owner  out  IDX_W  index of the requester whose word is on reg_d.
- busy  out  1  high while a grant is active.
- done  out  1  one-cycle pulse after a grant ends.
- truncated  out  1  one-cycle pulse with done when the grant ended by MAX_BEATS rather than last.

Behaviour:
- Reset: asynchronous, active-low; all state clears immediately, not on the next edge.
  - State IDLE, rr_ptr=0, owner=0, beat_cnt=0.
  - All outputs 0; req_ready therefore drops in the same instant.
- State IDLE:
  - busy=0, req_ready=0.
  - If any req_valid bit is set, pick the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - Register that index as owner, clear beat_cnt, go to GRANT.
  - The arbitration cycle transfers no data.
- State GRANT:
  - busy=1; req_ready[owner]=1, driven combinationally from the state and owner registers only (no path from req_valid).
  - A beat is accepted when req_valid[owner] && req_ready[owner].
  - On an accepted beat:
    - Next cycle: reg_enable=1, reg_d=req_data[owner], reg_owner=owner.
    - beat_cnt increments.
  - With no accepted beat: reg_enable=0, and reg_d/reg_owner hold their values.
  - Release, on the accepting beat, when either:
    - req_last[owner] is set; or
    - the beat is beat_cnt==MAX_BEATS-1.
  - On release:
    - Go to IDLE.
    - rr_ptr = owner+1, wrapping to 0 at NUM_REQ.
    - Next cycle: done=1, and truncated=1 only if the release was by count without last.
  - A requester dropping valid mid-burst does not end the grant; the arbiter waits indefinitely.
- Latency:
  - 1 cycle from acceptance to reg_enable.
  - Minimum 2 cycles from the first valid to the first acceptance.
  - Back-to-back grants have a 1-cycle IDLE gap.
- Simultaneous events:
  - Valid/last/data from non-owners are ignored.
  - done for the previous grant and a new arbitration can occur in the same cycle.
- Fairness: a requester waits at most (NUM_REQ-1) grants of at most MAX_BEATS beats each, plus the gaps.
- Width: beat_cnt is $clog2(MAX_BEATS+1) bits; its compare is exact; it never wraps.

Decomposition:
- Package reg_arb_pkg:
  - state enum {IDLE, GRANT}.
  - A function that returns the round-robin first-set index from a request vector and pointer.
- Sub-module rr_picker: combinational round-robin selector (request vector, ptr → index, found).
- The arbiter instantiates one RegisterFDRE (SIZE+IDX_W wide) for the reg_d/reg_owner output stage.

Test Plan:
- Single requester: NUM_REQ=4; req 2 sends 3 words A,B,C with last on C.
  - req_ready[2] high from cycle 2; reg_enable pulses carry A,B,C with reg_owner=2.
  - done pulses 1 cycle after C; truncated=0.
- Round-robin: all 4 requesters hold valid with single-word bursts from reset.
  - Grant order is 0,1,2,3,0; exactly one req_ready bit is set per cycle.
- MAX_BEATS=4: req 1 streams 6 words without last.
  - Grant ends after word 4, with done=1 and truncated=1.
  - Req 1 is then re-granted only after any other pending requester; words 5 and 6 follow in a new grant.
- Valid gaps: req 0 sends word, stalls 3 cycles, sends last word.
  - busy stays 1 and no other requester is granted.
  - reg_enable=0 during the stall, and reg_d holds the first word.
- Async reset mid-burst: drop resetn between clock edges while in GRANT.
  - req_ready, busy and reg_enable are 0 before the next edge.
  - After release, arbitration restarts from rr_ptr=0.
- Wrap-around: rr_ptr=3 (after a grant to req 2) with only req 0 and req 3 valid.
  - Req 3 is granted first; rr_ptr wraps to 0; req 0 is granted next.
